// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA stores feed a byte FIFO that is drained as 8N1 frames on tx.
// Optional even-parity bit between data and stop when UART_PARITY_EN is defined.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
`ifdef UART_PARITY_EN
    logic            parity_q, parity_d;
`endif
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];

    logic            hit_s, empty_s, full_s, busy_s, tick_s;
    logic            push_req_s, push_s, pop_s, ovf_set_s, ovf_clr_s;
    logic [7:0]      head_s;
    logic            unused_s;

    assign hit_s      = (addr[31:3] == BASE_ADDR[31:3]);
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign busy_s     = (state_q != S_IDLE) || !empty_s;
    assign head_s     = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign tick_s     = (div_q == DIV_LAST);
    // Fullness is judged before the edge, so a same-edge pop never rescues a push.
    assign push_req_s = hit_s && mem_write && !addr[2];
    assign push_s     = push_req_s && !full_s;
    assign ovf_set_s  = push_req_s && full_s;
    assign ovf_clr_s  = hit_s && mem_write && addr[2] && wdata[3];
    assign unused_s   = ^{addr[1:0], wdata[31:8]};

    assign hit   = hit_s;
    assign busy  = busy_s;
    assign tx    = tx_q;

    // Load data decode: only STATUS returns a non-zero value.
    always_comb begin
        rdata = 32'd0;
        if (hit_s && mem_read && addr[2]) begin
            rdata = {28'd0, ovf_q, busy_s, empty_s, full_s};
        end else begin
            rdata = 32'd0;
        end
    end

    // Sticky overflow flag; a set on the same edge as a clear takes priority.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Frame sequencer next state, counters and FIFO pop.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef UART_PARITY_EN
        parity_d  = parity_q;
`endif
        pop_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d     = {DW{1'b0}};
                bit_cnt_d = 3'd0;
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    shift_d  = head_s;
`ifdef UART_PARITY_EN
                    parity_d = ^head_s;
`endif
                    state_d  = S_START;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    div_d     = {DW{1'b0}};
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    div_d     = div_q + DW'(1);
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    div_d   = {DW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tick_s) begin
                    div_d   = {DW{1'b0}};
                    state_d = S_STOP;
                end else begin
                    div_d   = div_q + DW'(1);
                end
            end
`endif
            S_STOP: begin
                if (tick_s) begin
                    div_d = {DW{1'b0}};
                    // Chain straight into the next frame when data is waiting.
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        shift_d  = head_s;
`ifdef UART_PARITY_EN
                        parity_d = ^head_s;
`endif
                        state_d  = S_START;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level follows the current state; registering it adds one cycle of latency.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // Control state, pointers and line register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= {DW{1'b0}};
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
`ifdef UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= {(AW+1){1'b0}};
            rd_ptr_q  <= {(AW+1){1'b0}};
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef UART_PARITY_EN
            parity_q  <= parity_d;
`endif
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= wdata[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores push expected bytes, a line receiver pops and checks frames.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int CLK_DIV = 16;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        hit;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_count = 0;
    bit mon_act = 1'b0;
    logic [7:0] exp_q[$];
    int starts[$];

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .hit(hit), .rdata(rdata), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_write = 1'b1;
        tick();
        mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        store(BASE, {24'd0, b});
        exp_q.push_back(b);
    endtask

    task automatic rd_status(input logic [31:0] a, output logic [31:0] v);
        addr = a; mem_read = 1'b1;
        #1;
        v = rdata;
        mem_read = 1'b0; addr = 32'd0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_frames", rx_count, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || mon_act) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Single byte from idle: line falls two edges after the store, busy drops one edge past the frame.
    task automatic send_and_time(input logic [7:0] b);
        push_byte(b);
        check("busy_after_store", {31'd0, busy}, 32'd1);
        check("tx_e0", {31'd0, tx}, 32'd1);
        tick();
        check("tx_e1", {31'd0, tx}, 32'd1);
        tick();
        check("tx_fall_e2", {31'd0, tx}, 32'd0);
        repeat (FRAME - 2) tick();
        check("busy_last_cycle", {31'd0, busy}, 32'd1);
        tick();
        check("busy_done", {31'd0, busy}, 32'd0);
        check("tx_idle_high", {31'd0, tx}, 32'd1);
    endtask

    // Line receiver: detects start, samples mid-bit, checks the whole frame against the queue head.
    initial begin
        int cnt;
        logic [10:0] fr;
        logic [10:0] ef;
        logic [7:0] eb;
        cnt = 0;
        fr = 11'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_act = 1'b0;
            end else if (!mon_act) begin
                if (tx == 1'b0) begin
                    mon_act = 1'b1;
                    cnt = 0;
                    fr = 11'd0;
                    starts.push_back(cyc);
                end
            end else begin
                cnt++;
            end
            if (mon_act && !reset && cnt >= CLK_DIV / 2 && ((cnt - CLK_DIV / 2) % CLK_DIV) == 0) begin
                fr[(cnt - CLK_DIV / 2) / CLK_DIV] = tx;
                if ((cnt - CLK_DIV / 2) / CLK_DIV == NB - 1) begin
                    mon_act = 1'b0;
                    rx_count++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame got=%h exp=none", fr);
                    end else begin
                        eb = exp_q.pop_front();
`ifdef UART_PARITY_EN
                        ef = {1'b1, ^eb, eb, 1'b0};
`else
                        ef = {1'b0, 1'b1, eb, 1'b0};
`endif
                        check("frame", {21'd0, fr}, {21'd0, ef});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] st;
        int base_idx;
        int rx_before;

        // Reset state
        repeat (5) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rd_status(BASE + 32'd4, st);
        check("rst_status", st, 32'h2);
        reset = 1'b0;
        tick();

        // Single frame timing
        send_and_time(8'hA5);
        wait_frames(1, 50);

        // Five consecutive stores into a depth-4 FIFO; the first pops at once
        base_idx = starts.size();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'h55);
        rd_status(BASE + 32'd4, st);
        check("burst_status", st, 32'h5);
        wait_frames(6, 6 * FRAME + 100);
        for (int i = 0; i < 4; i++) begin
            check("back_to_back_gap", starts[base_idx + i + 1] - starts[base_idx + i], FRAME);
        end
        wait_idle(200);

        // Overflow: fill behind a frame in flight, then one more
        push_byte(8'h61);
        repeat (3) tick();
        push_byte(8'h62);
        push_byte(8'h63);
        push_byte(8'h64);
        push_byte(8'h65);
        store(BASE, 32'h0000_0066);
        rd_status(BASE + 32'd4, st);
        check("ovf_status", st, 32'hD);
        rd_status(BASE + 32'd6, st);
        check("status_low_bits_ignored", st, 32'hD);
        store(BASE + 32'd4, 32'h0000_0008);
        rd_status(BASE + 32'd4, st);
        check("ovf_cleared", st, 32'h5);
        rd_status(BASE, st);
        check("txdata_read_zero", st, 32'h0);
        addr = BASE + 32'd8; #1;
        check("miss_hit", {31'd0, hit}, 32'd0);
        addr = BASE + 32'd3; #1;
        check("hit_status", {31'd0, hit}, 32'd1);
        addr = 32'd0;
        wait_frames(11, 6 * FRAME + 100);
        wait_idle(200);
        check("queue_drained", exp_q.size(), 0);

        // Reset during data bit 3 of 0x37 (bit 3 is 0)
        push_byte(8'h37);
        push_byte(8'h38);
        repeat (70) tick();
        check("bit3_low", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        exp_q.delete();
        rx_before = rx_count;
        tick();
        check("abort_tx_high", {31'd0, tx}, 32'd1);
        rd_status(BASE + 32'd4, st);
        check("abort_status", st, 32'h2);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rd_status(BASE + 32'd4, st);
        check("post_reset_status", st, 32'h2);
        repeat (400) tick();
        check("no_frames_after_reset", rx_count, rx_before);
        check("post_reset_tx", {31'd0, tx}, 32'd1);

        // Parity-sensitive byte
        send_and_time(8'h07);
        wait_frames(rx_before + 1, 50);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
